// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet layout and merge-node state encoding.
package noc_pkg;

   localparam int PKT_W   = 9;
   localparam int ADDR_HI = 8;
   localparam int ADDR_LO = 5;

   typedef logic [PKT_W-1:0] pkt_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } merge_state_t;

   // Destination address field of a packet; the merge node never alters it.
   function automatic logic [ADDR_HI-ADDR_LO:0] pkt_addr(input pkt_t p);
      return p[ADDR_HI:ADDR_LO];
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant. A lone requester always wins;
// on contention the requester named by i_prio wins.
module rr_arb2
   import noc_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_prio,
   output logic [1:0] o_gnt,
   output logic       o_gnt_idx
);

   // Pick the winner from the request pair and the current priority.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      o_gnt     = 2'b00;
      o_gnt_idx = 1'b0;
      case (i_req)
         2'b01: begin
            o_gnt     = 2'b01;
            o_gnt_idx = 1'b0;
         end
         2'b10: begin
            o_gnt     = 2'b10;
            o_gnt_idx = 1'b1;
         end
         2'b11: begin
            o_gnt     = i_prio ? 2'b10 : 2'b01;
            o_gnt_idx = i_prio;
         end
         default: begin
            o_gnt     = 2'b00;
            o_gnt_idx = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/merge2_arbiter.sv
// Two-input up-tree merge node. Accepts one packet at a time from In0/In1
// (round-robin on contention), then holds it on Out together with the
// winning port index on S until both have been handshaken.
module merge2_arbiter
   import noc_pkg::*;
#(
   parameter int W = PKT_W
) (
   input  logic         CLK,
   input  logic         _RESET,
   input  logic [W-1:0] In0_data,
   input  logic         In0_valid,
   output logic         In0_ready,
   input  logic [W-1:0] In1_data,
   input  logic         In1_valid,
   output logic         In1_ready,
   output logic [W-1:0] Out_data,
   output logic         Out_valid,
   input  logic         Out_ready,
   output logic         S_data,
   output logic         S_valid,
   input  logic         S_ready
);

   merge_state_t r_state;
   merge_state_t w_state_nxt;
   logic         r_prio;
   logic [W-1:0] r_out_data;
   logic         r_out_valid;
   logic         r_s_data;
   logic         r_s_valid;

   logic [1:0]   w_req;
   logic [1:0]   w_gnt;
   logic         w_gnt_idx;
   logic [1:0]   w_in_ready;
   logic         w_accept;
   logic         w_out_valid_nxt;
   logic         w_s_valid_nxt;
   logic [W-1:0] w_sel_data;

   assign w_req      = {In1_valid, In0_valid};
   assign w_sel_data = w_gnt_idx ? In1_data : In0_data;

   rr_arb2 u_arb (
      .i_req     (w_req),
      .i_prio    (r_prio),
      .o_gnt     (w_gnt),
      .o_gnt_idx (w_gnt_idx)
   );

   // Next state, input readies and next output-valid values. Readies look
   // only at state, prio and the input valids, never at Out_ready/S_ready.
   always_comb begin
      w_state_nxt     = r_state;
      w_in_ready      = 2'b00;
      w_accept        = 1'b0;
      w_out_valid_nxt = r_out_valid;
      w_s_valid_nxt   = r_s_valid;
      case (r_state)
         IDLE: begin
            // Readies are held low while reset is asserted.
            if (_RESET) begin
               w_in_ready = w_gnt;
            end
            w_accept = |w_in_ready;
            if (w_accept) begin
               w_state_nxt     = BUSY;
               w_out_valid_nxt = 1'b1;
               w_s_valid_nxt   = 1'b1;
            end
         end
         BUSY: begin
            // Out and S retire independently; leave BUSY once both are gone.
            w_out_valid_nxt = r_out_valid & ~Out_ready;
            w_s_valid_nxt   = r_s_valid & ~S_ready;
            if (!w_out_valid_nxt && !w_s_valid_nxt) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge CLK or negedge _RESET) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      if (!_RESET) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Output registers and priority: capture winner on accept, retire valids
   // on handshakes. Reset drops any held packet.
   always_ff @(posedge CLK or negedge _RESET) begin
      if (!_RESET) begin
         r_prio      <= 1'b0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_s_data    <= 1'b0;
         r_s_valid   <= 1'b0;
      end else begin
         r_out_valid <= w_out_valid_nxt;
         r_s_valid   <= w_s_valid_nxt;
         if (w_accept) begin
            r_out_data <= w_sel_data;
            r_s_data   <= w_gnt_idx;
            r_prio     <= ~w_gnt_idx;
         end
      end
   end

   assign In0_ready = w_in_ready[0];
   assign In1_ready = w_in_ready[1];
   assign Out_data  = r_out_data;
   assign Out_valid = r_out_valid;
   assign S_data    = r_s_data;
   assign S_valid   = r_s_valid;

endmodule

// File: tb/tb_merge2_arbiter.sv
// Directed bench for merge2_arbiter: reset, single sender, contention,
// back-pressure, mid-operation reset and priority after a lone sender.
module tb_merge2_arbiter;

   logic       CLK;
   logic       _RESET;
   logic [8:0] In0_data;
   logic       In0_valid;
   logic       In0_ready;
   logic [8:0] In1_data;
   logic       In1_valid;
   logic       In1_ready;
   logic [8:0] Out_data;
   logic       Out_valid;
   logic       Out_ready;
   logic       S_data;
   logic       S_valid;
   logic       S_ready;

   int total = 0;
   int bad   = 0;

   merge2_arbiter dut (
      .CLK       (CLK),
      ._RESET    (_RESET),
      .In0_data  (In0_data),
      .In0_valid (In0_valid),
      .In0_ready (In0_ready),
      .In1_data  (In1_data),
      .In1_valid (In1_valid),
      .In1_ready (In1_ready),
      .Out_data  (Out_data),
      .Out_valid (Out_valid),
      .Out_ready (Out_ready),
      .S_data    (S_data),
      .S_valid   (S_valid),
      .S_ready   (S_ready)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Short asynchronous reset pulse placed between clock edges.
   task automatic pulse_reset();
      _RESET = 1'b0;
      #2;
      _RESET = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      _RESET = 1'b0; In0_valid = 1'b1; In0_data = 9'h055;
      In1_valid = 1'b0; In1_data = 9'h000; Out_ready = 1'b1; S_ready = 1'b1;
      tick(); tick();
      total++; if ({In0_ready, In1_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b want=00", {In0_ready, In1_ready}); end
      total++; if ({Out_valid, S_valid} !== 2'b00) begin bad++; $display("FAIL reset_valid got=%b want=00", {Out_valid, S_valid}); end
      total++; if ({Out_data, S_data} !== 10'h000) begin bad++; $display("FAIL reset_data got=%h want=000", {Out_data, S_data}); end
      _RESET = 1'b1; #1;
      total++; if ({In1_ready, In0_ready} !== 2'b01) begin bad++; $display("FAIL reset_first_ready got=%b want=01", {In1_ready, In0_ready}); end
      tick();
      In0_valid = 1'b0;
      total++; if ({Out_valid, S_valid, S_data, Out_data} !== {3'b110, 9'h055}) begin bad++; $display("FAIL reset_first_pkt got=%b%b%b %h want=110 055", Out_valid, S_valid, S_data, Out_data); end
      tick();
      total++; if ({Out_valid, S_valid} !== 2'b00) begin bad++; $display("FAIL reset_first_retire got=%b want=00", {Out_valid, S_valid}); end
   endtask

   task automatic test_single_sender();
      In1_valid = 1'b1; In1_data = 9'h1A5; #1;
      total++; if ({In1_ready, In0_ready} !== 2'b10) begin bad++; $display("FAIL single_ready got=%b want=10", {In1_ready, In0_ready}); end
      tick();
      In1_valid = 1'b0;
      total++; if ({Out_valid, S_valid, S_data, Out_data} !== {3'b111, 9'h1A5}) begin bad++; $display("FAIL single_out got=%b%b%b %h want=111 1a5", Out_valid, S_valid, S_data, Out_data); end
      total++; if ({In1_ready, In0_ready} !== 2'b00) begin bad++; $display("FAIL single_busy_ready got=%b want=00", {In1_ready, In0_ready}); end
      tick();
      In0_valid = 1'b1; In0_data = 9'h00C; #1;
      total++; if ({Out_valid, In0_ready} !== 2'b01) begin bad++; $display("FAIL single_idle got=%b want=01", {Out_valid, In0_ready}); end
      In0_valid = 1'b0; #1;
   endtask

   task automatic test_contention();
      logic       g;
      logic [8:0] pkt;
      pulse_reset();
      In0_valid = 1'b1; In0_data = 9'h011; In1_valid = 1'b1; In1_data = 9'h122;
      Out_ready = 1'b1; S_ready = 1'b1; #1;
      for (int k = 0; k < 4; k++) begin
         g   = k[0];
         pkt = g ? 9'h122 : 9'h011;
         total++; if ({In1_ready, In0_ready} !== (g ? 2'b10 : 2'b01)) begin bad++; $display("FAIL contend_grant%0d got=%b want=%b", k, {In1_ready, In0_ready}, g ? 2'b10 : 2'b01); end
         tick();
         total++; if ({Out_valid, S_data, Out_data} !== {1'b1, g, pkt}) begin bad++; $display("FAIL contend_out%0d got=%b%b %h want=1%b %h", k, Out_valid, S_data, Out_data, g, pkt); end
         total++; if ({In1_ready, In0_ready} !== 2'b00) begin bad++; $display("FAIL contend_busy%0d got=%b want=00", k, {In1_ready, In0_ready}); end
         tick();
      end
      In0_valid = 1'b0; In1_valid = 1'b0; #1;
   endtask

   task automatic test_back_pressure();
      In0_valid = 1'b1; In0_data = 9'h0F3; Out_ready = 1'b0; S_ready = 1'b1;
      tick();
      In0_data = 9'h1FF;
      total++; if ({Out_valid, S_valid, S_data} !== 3'b110) begin bad++; $display("FAIL bp_accept got=%b want=110", {Out_valid, S_valid, S_data}); end
      tick();
      total++; if ({Out_valid, S_valid} !== 2'b10) begin bad++; $display("FAIL bp_s_done got=%b want=10", {Out_valid, S_valid}); end
      for (int c = 0; c < 4; c++) begin
         total++; if ({Out_valid, Out_data, In0_ready, In1_ready} !== {1'b1, 9'h0F3, 2'b00}) begin bad++; $display("FAIL bp_hold%0d got=%b %h %b want=1 0f3 00", c, Out_valid, Out_data, {In0_ready, In1_ready}); end
         tick();
      end
      Out_ready = 1'b1;
      total++; if ({Out_valid, Out_data, In0_ready} !== {1'b1, 9'h0F3, 1'b0}) begin bad++; $display("FAIL bp_last got=%b %h %b want=1 0f3 0", Out_valid, Out_data, In0_ready); end
      tick();
      total++; if ({Out_valid, In0_ready} !== 2'b01) begin bad++; $display("FAIL bp_idle got=%b want=01", {Out_valid, In0_ready}); end
      In0_valid = 1'b0; #1;
   endtask

   task automatic test_mid_reset();
      In0_valid = 1'b1; In0_data = 9'h0AA; Out_ready = 1'b0; S_ready = 1'b0;
      tick();
      In0_valid = 1'b0;
      total++; if ({Out_valid, S_valid, Out_data} !== {2'b11, 9'h0AA}) begin bad++; $display("FAIL midrst_busy got=%b %h want=11 0aa", {Out_valid, S_valid}, Out_data); end
      #1; _RESET = 1'b0; #1;
      total++; if ({Out_valid, S_valid, Out_data} !== {2'b00, 9'h000}) begin bad++; $display("FAIL midrst_async got=%b %h want=00 000", {Out_valid, S_valid}, Out_data); end
      _RESET = 1'b1; Out_ready = 1'b1; S_ready = 1'b1;
      tick();
      total++; if ({Out_valid, S_valid} !== 2'b00) begin bad++; $display("FAIL midrst_dropped got=%b want=00", {Out_valid, S_valid}); end
      In0_valid = 1'b1; In1_valid = 1'b1; #1;
      total++; if ({In1_ready, In0_ready} !== 2'b01) begin bad++; $display("FAIL midrst_prio got=%b want=01", {In1_ready, In0_ready}); end
      In0_valid = 1'b0; In1_valid = 1'b0; #1;
   endtask

   task automatic test_prio_after_lone();
      pulse_reset();
      Out_ready = 1'b1; S_ready = 1'b1;
      In0_valid = 1'b1; In0_data = 9'h0C1;
      tick(); In0_valid = 1'b0; tick();
      In0_valid = 1'b1; In1_valid = 1'b1; In1_data = 9'h1C2; #1;
      total++; if ({In1_ready, In0_ready} !== 2'b10) begin bad++; $display("FAIL lone0_then_both got=%b want=10", {In1_ready, In0_ready}); end
      tick(); In0_valid = 1'b0; In1_valid = 1'b0;
      total++; if ({S_data, Out_data} !== {1'b1, 9'h1C2}) begin bad++; $display("FAIL lone0_winner got=%b %h want=1 1c2", S_data, Out_data); end
      tick();
      In1_valid = 1'b1; In1_data = 9'h133;
      tick(); In1_valid = 1'b0; tick();
      In0_valid = 1'b1; In1_valid = 1'b1; #1;
      total++; if ({In1_ready, In0_ready} !== 2'b01) begin bad++; $display("FAIL lone1_then_both got=%b want=01", {In1_ready, In0_ready}); end
      tick(); In0_valid = 1'b0; In1_valid = 1'b0;
      total++; if ({S_data, Out_data} !== {1'b0, 9'h0C1}) begin bad++; $display("FAIL lone1_winner got=%b %h want=0 0c1", S_data, Out_data); end
      tick();
   endtask

   initial begin
      _RESET = 1'b0; In0_valid = 1'b0; In1_valid = 1'b0;
      In0_data = '0; In1_data = '0; Out_ready = 1'b0; S_ready = 1'b0;
      test_reset();
      test_single_sender();
      test_contention();
      test_back_pressure();
      test_mid_reset();
      test_prio_after_lone();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/merge2_arbiter.md
# merge2_arbiter

Two-input merge node for the up-tree direction of the NoC, the counterpart to the decoder leaf/tree nodes that split traffic down-tree. It accepts 9-bit packets from two child channels (In0, In1), arbitrates round-robin when both offer at once, and forwards the winner unchanged on one parent channel (Out). It also reports the winning port index on a separate 1-bit channel (S), which matches the decoder's S select channel. The block is the clocked RTL body. The team's channel wrappers convert each valid/ready pair to the e1of2 channel of the same name.

## Interface
- W, 9, packet width; bits [8:5] are the destination address, bits [4:0] are the payload; the block does not modify either field
- CLK  in  1  clock
- _RESET  in  1  reset, asynchronous, active-low
- In0_data  in  W  packet from child 0
- In0_valid  in  1  child 0 offers a packet
- In0_ready  out  1  block accepts In0 this cycle
- In1_data / In1_valid / In1_ready  same as In0, for child 1
- Out_data  out  W  forwarded packet
- Out_valid  out  1  Out_data is valid
- Out_ready  in  1  parent accepts Out
- S_data  out  1  index of the port that won (0 = In0, 1 = In1)
- S_valid  out  1  S_data is valid
- S_ready  in  1  consumer accepts S

## Operation
- Two states: IDLE and BUSY. The block also keeps a 1-bit priority register prio.
- In IDLE:
  - grant = In0 if only In0_valid is high.
  - grant = In1 if only In1_valid is high.
  - grant = prio if both are valid.
  - No grant if neither is valid.
  - In{grant}_ready = 1 combinationally and the other ready = 0. Both readies are 0 when there is no grant.
- On accept (IDLE, valid and ready both high):
  - Register the packet into Out_data and the grant into S_data.
  - Set Out_valid = 1 and S_valid = 1.
  - Set prio = ~grant.
  - Go to BUSY.
- In BUSY:
  - Both readies = 0.
  - Out_valid clears on an Out handshake; S_valid clears on an S handshake. The two handshakes are independent and may complete in the same cycle or in either order.
  - Out_data and S_data stay stable while their valid is high. Once Out_valid is set, it drops only on a handshake, never on a change of inputs.
- BUSY returns to IDLE on the clock edge at which the last outstanding valid clears.
- prio updates on every accept, including an accept with no contention, so a lone sender loses priority on the next contended cycle.
- Reset, including mid-packet: state = IDLE, prio = 0, Out_valid = 0, S_valid = 0, Out_data = 0, S_data = 0. Any held packet is dropped.

## Timing
- Latency: a packet accepted at edge n is on Out with Out_valid = 1 in cycle n+1.
- Peak throughput: one packet every 2 cycles (the accept cycle, then one BUSY cycle with both readies high).
- If Out_ready or S_ready is low, BUSY extends by one cycle per stalled cycle.
- Readies depend combinationally on state, prio and the input valids. They never depend on Out_ready or S_ready, so there is no combinational path from Out/S back to In.
- Nothing else is combinational: Out_data, Out_valid, S_data and S_valid are all driven straight from flops.
- A valid that drops before it is accepted is ignored; the block never latches partial data.

## Structure
- Shared package noc_pkg:
  - PKT_W = 9
  - ADDR_HI = 8, ADDR_LO = 5
  - typedef pkt_t = logic [PKT_W-1:0]
  - enum merge_state_t {IDLE, BUSY}
- One natural sub-module, rr_arb2: combinational 2-way round-robin grant taking (req[1:0], prio) and producing (gnt[1:0], gnt_idx).

## Test plan
- Reset: assert _RESET low with In0_valid = 1 -> all outputs 0, both readies 0 during reset. After release the first packet is accepted from In0.
- Single sender: In1 sends 9'h1A5, both downstream readies held high -> In1_ready = 1 at cycle 0, Out_data = 9'h1A5 with S_data = 1 at cycle 1, IDLE at cycle 2.
- Contention:
  - Both valid every cycle: In0 = 9'h011, In1 = 9'h122.
  - Required grant order after reset: In0, In1, In0, In1.
  - S_data follows 0, 1, 0, 1 and there is one accept every 2 cycles.
- Back-pressure: Out_ready = 0 for 5 cycles while S_ready = 1 -> S handshakes at cycle 1, Out_data stays stable and both readies stay 0 until Out_ready rises; IDLE on the edge after the Out handshake.
- Mid-operation reset: assert _RESET while in BUSY with Out_valid = 1 -> Out_valid and S_valid drop immediately (asynchronously), the packet is never delivered, and prio = 0 afterwards.
- Priority after a lone sender: In1 alone sends one packet, then both send -> In0 wins (prio = ~1 = 0).
